hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised ID-stage hazard unit using a per-register scoreboard instead of comparing
//  against fixed EXE/MEM destinations. Tracks every in-flight write for PIPE_DEPTH stages.
//  Drives the ID stall (hazard_detected) and per-operand forwarding selects.
//  Supports a no-forwarding mode and a forwarding mode (only load-use stalls).
// PARAMETERS
//  REG_COUNT   16  architectural registers tracked
//  REG_ADDR_W  4   register index width, $clog2(REG_COUNT)
//  PIPE_DEPTH  2   stages between ID exit and register-file write (EXE, MEM)
//  LOAD_LAT    1   stages a load result stays unforwardable after ID exit (1..PIPE_DEPTH)
//  SEL_W       2   forwarding select width, $clog2(PIPE_DEPTH+1)
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           synchronous reset, active high
//  freeze           in   1           pipeline freeze; scoreboard holds, no issue
//  flush            in   1           ID instruction squashed this cycle; no issue
//  mode             in   1           0 = no forwarding, 1 = forwarding enabled
//  id_valid         in   1           valid instruction in ID
//  src1             in   REG_ADDR_W  first source register
//  src2             in   REG_ADDR_W  second source register
//  two_src          in   1           src2 is a real operand
//  id_wb_en         in   1           ID instruction writes a register
//  id_dest          in   REG_ADDR_W  ID instruction destination
//  id_mem_r_en      in   1           ID instruction is a load
//  hazard_detected  out  1           stall IF/ID this cycle
//  fwd_sel1         out  SEL_W       src1 source: 0 = reg file, k = output of stage k (1 = EXE)
//  fwd_sel2         out  SEL_W       src2 source, same encoding
//  stall_count      out  32          stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - State per register r: cnt[r] (0..PIPE_DEPTH) and ld[r]. cnt = 0 means no pending write.
//  - Issue = id_valid & id_wb_en & ~hazard_detected & ~flush & ~freeze.
//  - Each edge, non-freeze: all nonzero cnt decrement by 1. On issue, cnt[id_dest] <= PIPE_DEPTH
//    and ld[id_dest] <= id_mem_r_en. Issue overrides the decrement for that register.
//    A newer write therefore replaces an older one to the same register (newest wins).
//  - Freeze: every cnt/ld holds and there is no issue. Freeze has priority over flush.
//  - Operand matching, all combinational from state and inputs:
//    - src1 is live whenever id_valid = 1.
//    - src2 is live only if two_src = 1.
//    - A live source s is pending iff cnt[s] != 0.
//  - mode = 0: hazard iff any live source is pending. fwd_sel1 = fwd_sel2 = 0.
//  - mode = 1: hazard iff a live source is pending with ld = 1 and cnt > PIPE_DEPTH - LOAD_LAT.
//    - When there is no hazard and the source is pending: fwd_sel = PIPE_DEPTH - cnt + 1.
//    - Otherwise fwd_sel = 0.
//    - Selects are valid only when hazard_detected = 0.
//  - id_valid = 0 forces hazard_detected = 0 and both selects = 0.
//  - Reset: all cnt = 0, all ld = 0, stall_count = 0. Outputs then read hazard 0, selects 0.
//  - The output value during the reset cycle is 0.
//  - A mid-flight reset discards all pending entries. No hazard is raised for them afterwards.
//  - Latency: the issue in cycle t is visible as a pending entry to the ID instruction in t+1.
//  - src1 = src2 = pending register: both selects report the same stage.
//  - No register index is special-cased; R15 is tracked like any other register.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stall_count increments each non-freeze cycle with
//    hazard_detected = 1. It saturates at 32'hFFFF_FFFF and is cleared by rst.
//  HAZARD_STATS_EN undefined: no counter logic; stall_count is constant 0.
// TESTING (defaults: PIPE_DEPTH = 2, LOAD_LAT = 1)
//  1. Reset: rst 2 cycles, then id_valid=1 src1=3 -> hazard 0, fwd_sel1 0, stall_count 0.
//  2. mode=0: issue dest=5 wb_en=1; next 2 cycles src1=5 -> hazard 1,1.
//     Third cycle -> hazard 0, fwd_sel1 0.
//  3. mode=1 ALU: issue dest=5 non-load; next cycle src2=5 two_src=1 -> hazard 0, fwd_sel2 1.
//     Following cycle -> fwd_sel2 2. Then -> fwd_sel2 0.
//  4. mode=1 load: issue load dest=7; next cycle src1=7 -> hazard 1.
//     Following cycle -> hazard 0, fwd_sel1 2.
//  5. Freeze: issue dest=5; freeze=1 for 3 cycles with src1=5, mode=0 -> hazard held 1.
//     After release -> hazard 1 then 0 (2 cycles total unfrozen).
//  6. two_src=0 with src2=5 pending -> hazard 0.
//     flush=1 with wb_en dest=9 -> src1=9 next cycle, hazard 0.
//     HAZARD_STATS_EN: scenario 2 -> stall_count = 2.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - ID-stage scoreboard hazard unit with per-operand forwarding selects
// Optional stall-cycle counter enabled by HAZARD_STATS_EN.
module hazard_scoreboard_unit #(
    parameter int REG_COUNT  = 16,
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  mode,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_mem_r_en,
    output logic                  hazard_detected,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [31:0]           stall_count
);

    localparam logic [SEL_W-1:0] DEPTH_V = SEL_W'(PIPE_DEPTH);
    localparam logic [SEL_W-1:0] SEL_BASE = SEL_W'(PIPE_DEPTH + 1);
    // A load result is still unforwardable while its count is above this threshold.
    localparam logic [SEL_W-1:0] LOAD_TH = SEL_W'(PIPE_DEPTH - LOAD_LAT);

    logic [SEL_W-1:0] cnt [REG_COUNT];
    logic             ld  [REG_COUNT];

    logic             live1, live2;
    logic             pend1, pend2;
    logic             ldhaz1, ldhaz2;
    logic [SEL_W-1:0] c1, c2;
    logic             issue;

    always_comb begin
        c1     = cnt[src1];
        c2     = cnt[src2];
        live1  = id_valid & ~rst;
        live2  = id_valid & two_src & ~rst;
        pend1  = live1 & (c1 != '0);
        pend2  = live2 & (c2 != '0);
        ldhaz1 = pend1 & ld[src1] & (c1 > LOAD_TH);
        ldhaz2 = pend2 & ld[src2] & (c2 > LOAD_TH);

        hazard_detected = 1'b0;
        fwd_sel1        = '0;
        fwd_sel2        = '0;
        if (mode) begin
            hazard_detected = ldhaz1 | ldhaz2;
            if (!(ldhaz1 | ldhaz2)) begin
                if (pend1) fwd_sel1 = SEL_BASE - c1;
                if (pend2) fwd_sel2 = SEL_BASE - c2;
            end
        end else begin
            hazard_detected = pend1 | pend2;
        end
    end

    assign issue = id_valid & id_wb_en & ~hazard_detected & ~flush & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt[i] <= '0;
                ld[i]  <= 1'b0;
            end
        end else if (!freeze) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
            end
            // Placed after the decrement loop so a new write to the same register wins.
            if (issue) begin
                cnt[id_dest] <= DEPTH_V;
                ld[id_dest]  <= id_mem_r_en;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!freeze && hazard_detected && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed vector bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst, freeze, flush, mode, id_valid, two_src, id_wb_en, id_mem_r_en;
    logic [3:0] src1, src2, id_dest;
    logic       hazard_detected;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;

    hazard_scoreboard_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .mode(mode),
        .id_valid(id_valid), .src1(src1), .src2(src2), .two_src(two_src),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en),
        .hazard_detected(hazard_detected), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       flush;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two_src;
        logic       wb_en;
        logic [3:0] dest;
        logic       load;
        logic       exp_h;
        logic [1:0] exp_s1;
        logic [1:0] exp_s2;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(logic md, logic fl, logic [3:0] s1, logic [3:0] s2, logic ts,
                                logic we, logic [3:0] d, logic lo,
                                logic h, logic [1:0] e1, logic [1:0] e2);
        vec_t v;
        v.mode = md; v.flush = fl; v.src1 = s1; v.src2 = s2; v.two_src = ts;
        v.wb_en = we; v.dest = d; v.load = lo;
        v.exp_h = h; v.exp_s1 = e1; v.exp_s2 = e2;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        freeze = 0; flush = 0; mode = 0; id_valid = 0; two_src = 0;
        id_wb_en = 0; id_mem_r_en = 0; src1 = 0; src2 = 0; id_dest = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0);
        tbl[1]  = mk(0, 0, 5, 0, 0, 0, 0, 0,  1, 0, 0);
        tbl[2]  = mk(0, 0, 5, 0, 0, 0, 0, 0,  1, 0, 0);
        tbl[3]  = mk(0, 0, 5, 0, 0, 0, 0, 0,  0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 2);
        tbl[7]  = mk(1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 7, 1,  0, 0, 0);
        tbl[9]  = mk(1, 0, 7, 0, 0, 0, 0, 0,  1, 0, 0);
        tbl[10] = mk(1, 0, 7, 0, 0, 0, 0, 0,  0, 2, 0);
        tbl[11] = mk(1, 0, 7, 0, 0, 0, 0, 0,  0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0);
        tbl[13] = mk(0, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0);
        tbl[14] = mk(1, 0, 5, 5, 1, 0, 0, 0,  0, 2, 2);
        tbl[15] = mk(0, 1, 0, 0, 0, 1, 9, 0,  0, 0, 0);
        tbl[16] = mk(0, 0, 9, 0, 0, 0, 0, 0,  0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 15, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 15, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[20] = mk(0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 1, 3, 1,  0, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0);
        tbl[23] = mk(1, 0, 3, 0, 0, 0, 0, 0,  0, 1, 0);
        tbl[24] = mk(1, 0, 3, 0, 0, 0, 0, 0,  0, 0, 0);

        // Reset sequence
        idle_inputs();
        rst = 1;
        id_valid = 1; src1 = 3;
        #2;
        chk("reset_cycle_hazard", {31'd0, hazard_detected}, 0);
        next_cycle();
        next_cycle();
        rst = 0;
        #3;
        chk("reset_hazard", {31'd0, hazard_detected}, 0);
        chk("reset_sel1", {30'd0, fwd_sel1}, 0);
        chk("reset_stall_count", stall_count, 0);

        // Table-driven vectors, one per cycle; tbl[24] sees id_valid=0 with R3 pending
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            idle_inputs();
            mode = tbl[i].mode; flush = tbl[i].flush; id_valid = (i != 24);
            src1 = tbl[i].src1; src2 = tbl[i].src2; two_src = tbl[i].two_src;
            id_wb_en = tbl[i].wb_en; id_dest = tbl[i].dest; id_mem_r_en = tbl[i].load;
            @(negedge clk);
            chk($sformatf("vec%0d_hazard", i), {31'd0, hazard_detected}, {31'd0, tbl[i].exp_h});
            chk($sformatf("vec%0d_sel1", i), {30'd0, fwd_sel1}, {30'd0, tbl[i].exp_s1});
            chk($sformatf("vec%0d_sel2", i), {30'd0, fwd_sel2}, {30'd0, tbl[i].exp_s2});
            if (tbl[i].exp_h) exp_stalls++;
        end
`ifdef HAZARD_STATS_EN
        chk("stall_count_table", stall_count, exp_stalls);
`else
        chk("stall_count_const", stall_count, 0);
`endif

        // Freeze holds the scoreboard: issue R5, freeze 3 cycles, then release
        next_cycle();
        idle_inputs();
        id_valid = 1; id_wb_en = 1; id_dest = 5;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            idle_inputs();
            freeze = 1; id_valid = 1; src1 = 5; id_wb_en = 1; id_dest = 10;
            @(negedge clk);
            chk($sformatf("freeze%0d_hazard", k), {31'd0, hazard_detected}, 1);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            idle_inputs();
            id_valid = 1; src1 = 5;
            @(negedge clk);
            chk($sformatf("unfreeze%0d_hazard", k), {31'd0, hazard_detected}, (k < 2) ? 1 : 0);
        end
        next_cycle();
        idle_inputs();
        id_valid = 1; src1 = 10;
        @(negedge clk);
        chk("freeze_blocked_issue", {31'd0, hazard_detected}, 0);

        // Mid-flight reset discards pending writes
        next_cycle();
        idle_inputs();
        id_valid = 1; id_wb_en = 1; id_dest = 6;
        next_cycle();
        idle_inputs();
        rst = 1; id_valid = 1; src1 = 6;
        @(negedge clk);
        chk("midreset_cycle_hazard", {31'd0, hazard_detected}, 0);
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("midreset_after_hazard", {31'd0, hazard_detected}, 0);
        chk("midreset_stall_count", stall_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
